// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that frames a UART byte stream (32-bit LE
// length header followed by LE words) into instruction-memory writes, holding
// the core in reset while loading and reporting completion or error.
module imem_loader #(
  parameter int IMEM_DEPTH     = 1024,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int ADDR_W         = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flash,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic              busy
);

  localparam int                TCNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]       LEN_MAX   = 32'(IMEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state, state_n;
  logic                flash_q, rise_q;
  logic [1:0]          byte_idx, byte_idx_n;
  logic [ADDR_W:0]     word_idx, word_idx_n;
  logic [31:0]         len_r, len_n, len_full;
  logic [23:0]         wbuf, wbuf_n;
  logic [TCNT_W-1:0]   tcnt, tcnt_n;
  logic                wr_n;
  logic                restart;

  // Edge detector: the rise is registered so it is seen one cycle after flash.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      flash_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      flash_q <= flash;
      rise_q  <= flash & ~flash_q;
    end
  end

  // Full header value as it would be after shifting in the current byte.
  assign len_full = {byte_data, len_r[31:8]};
  // A rise restarts from any state except the single-cycle DONE.
  assign restart  = rise_q && (state != S_DONE);

  // Next-state and datapath update logic.
  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    state_n    = state;
    byte_idx_n = byte_idx;
    word_idx_n = word_idx;
    len_n      = len_r;
    wbuf_n     = wbuf;
    tcnt_n     = tcnt;
    wr_n       = 1'b0;

    if (restart) begin
      state_n    = S_LEN;
      byte_idx_n = '0;
      word_idx_n = '0;
      len_n      = '0;
      wbuf_n     = '0;
      tcnt_n     = '0;
    end else begin
      case (state)
        S_LEN, S_DATA: begin
          if (byte_valid) begin
            tcnt_n     = '0;
            byte_idx_n = byte_idx + 2'd1;
            if (state == S_LEN) begin
              len_n = len_full;
              if (byte_idx == 2'd3) begin
                if (len_full == 32'd0)         state_n = S_DONE;
                else if (len_full > LEN_MAX)   state_n = S_ERR;
                else                           state_n = S_DATA;
              end
            end else begin
              wbuf_n = {byte_data, wbuf[23:8]};
              if (byte_idx == 2'd3) begin
                wr_n       = 1'b1;
                word_idx_n = word_idx + (ADDR_W+1)'(1);
                if (32'(word_idx) == len_r - 32'd1) state_n = S_DONE;
              end
            end
          end else if (tcnt == TCNT_LAST) begin
            // Partial word in wbuf is abandoned; restart clears it.
            state_n = S_ERR;
          end else begin
            tcnt_n = tcnt + TCNT_W'(1);
          end
        end
        S_DONE:  state_n = S_IDLE;
        default: state_n = state;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      byte_idx <= '0;
      word_idx <= '0;
      len_r    <= '0;
      wbuf     <= '0;
      tcnt     <= '0;
    end else begin
      state    <= state_n;
      byte_idx <= byte_idx_n;
      word_idx <= word_idx_n;
      len_r    <= len_n;
      wbuf     <= wbuf_n;
      tcnt     <= tcnt_n;
    end
  end

  // Registered outputs, decoded from the next state so the final write and
  // the core release land on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      busy       <= 1'b0;
    end else begin
      imem_we <= wr_n;
      if (wr_n) begin
        imem_waddr <= word_idx[ADDR_W-1:0];
        imem_wdata <= {byte_data, wbuf};
      end
      cpu_hold   <= (state_n == S_LEN) || (state_n == S_DATA) || (state_n == S_ERR);
      busy       <= (state_n == S_LEN) || (state_n == S_DATA);
      load_done  <= (state_n == S_DONE);
      load_error <= (state_n == S_ERR);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed stimulus against imem_loader with a queue-based
// reference model checked every cycle plus hand-computed literal expectations.
module tb_imem_loader;

  localparam int IMEM_DEPTH     = 1024;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int ADDR_W         = $clog2(IMEM_DEPTH);

  logic              clk = 1'b0;
  logic              rst;
  logic              flash;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;
  logic              busy;

  imem_loader #(
    .IMEM_DEPTH     (IMEM_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flash      (flash),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (loader behaviour in queue terms) -----
  typedef enum {M_IDLE, M_LEN, M_DATA, M_DONE, M_ERR} mode_t;
  mode_t       mode = M_IDLE;
  bit          m_started = 0;
  bit          m_in_rst;
  bit          m_prev, m_pend;
  logic [7:0]  m_hdr[$];
  logic [7:0]  m_wq[$];
  logic [31:0] m_len;
  int          m_written, m_idle;
  bit          e_we;
  logic [31:0] e_waddr, e_wdata;

  task automatic model_step();
    bit r;
    m_started = 1;
    e_we      = 0;
    if (rst) begin
      mode = M_IDLE; m_prev = 0; m_pend = 0; m_in_rst = 1;
      m_hdr.delete(); m_wq.delete(); m_written = 0; m_idle = 0; m_len = 0;
      e_waddr = 0; e_wdata = 0;
    end else begin
      m_in_rst = 0;
      r      = m_pend;
      m_pend = flash && !m_prev;
      m_prev = flash;
      if (mode == M_DONE) mode = M_IDLE;
      else if (r) begin
        mode = M_LEN; m_hdr.delete(); m_wq.delete();
        m_written = 0; m_idle = 0; m_len = 0;
      end else if (mode == M_LEN || mode == M_DATA) begin
        if (byte_valid) begin
          m_idle = 0;
          if (mode == M_LEN) begin
            m_hdr.push_back(byte_data);
            if (m_hdr.size() == 4) begin
              m_len = {m_hdr[3], m_hdr[2], m_hdr[1], m_hdr[0]};
              m_hdr.delete();
              if (m_len == 0)                  mode = M_DONE;
              else if (m_len > 32'(IMEM_DEPTH)) mode = M_ERR;
              else                              mode = M_DATA;
            end
          end else begin
            m_wq.push_back(byte_data);
            if (m_wq.size() == 4) begin
              e_we    = 1;
              e_waddr = 32'(m_written);
              e_wdata = {m_wq[3], m_wq[2], m_wq[1], m_wq[0]};
              m_wq.delete();
              m_written++;
              if (32'(m_written) == m_len) mode = M_DONE;
            end
          end
        end else begin
          m_idle++;
          if (m_idle == TIMEOUT_CYCLES) mode = M_ERR;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare and write monitor -------------------
  int          we_cnt, done_cnt;
  logic [31:0] w_addr[8];
  logic [31:0] w_data[8];

  task automatic clear_log();
    we_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      w_addr[i] = 32'hFFFF_FFFF;
      w_data[i] = 32'hFFFF_FFFF;
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (m_started) begin
      check("cpu_hold",   32'(cpu_hold),   32'((mode == M_LEN) || (mode == M_DATA) || (mode == M_ERR)));
      check("busy",       32'(busy),       32'((mode == M_LEN) || (mode == M_DATA)));
      check("load_done",  32'(load_done),  32'(mode == M_DONE));
      check("load_error", 32'(load_error), 32'(mode == M_ERR));
      check("imem_we",    32'(imem_we),    32'(e_we));
      if (e_we || m_in_rst) begin
        check("imem_waddr", 32'(imem_waddr), e_waddr);
        check("imem_wdata", imem_wdata,      e_wdata);
      end
    end
    if (imem_we === 1'b1) begin
      if (we_cnt < 8) begin
        w_addr[we_cnt] = 32'(imem_waddr);
        w_data[we_cnt] = imem_wdata;
      end
      we_cnt++;
    end
    if (load_done === 1'b1) done_cnt++;
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  // Sends w as four back-to-back bytes, least significant first.
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Raise flash for two edges; the loader is in LEN before the next byte.
  task automatic start_load();
    flash      = 1'b1;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    flash = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flash = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    clear_log();
    repeat (3) @(negedge clk);
    #1;
    check("rst_cpu_hold", 32'(cpu_hold), 0);
    check("rst_busy",     32'(busy),     0);
    check("rst_we",       32'(imem_we),  0);
    rst = 1'b0;
    idle(2);

    // Normal load: 02 00 00 00 | 13 00 00 00 | B3 00 10 00
    clear_log();
    start_load();
    #1 check("norm_busy_on", 32'(busy), 1);
    send_word(32'h0000_0002);
    send_word(32'h0000_0013);
    send_word(32'h0010_00B3);
    idle(3);
    #1;
    check("norm_writes",  32'(we_cnt),   2);
    check("norm_addr0",   w_addr[0],     0);
    check("norm_data0",   w_data[0],     32'h0000_0013);
    check("norm_addr1",   w_addr[1],     1);
    check("norm_data1",   w_data[1],     32'h0010_00B3);
    check("norm_done",    32'(done_cnt), 1);
    check("norm_hold",    32'(cpu_hold), 0);

    // Oversize header 01 04 00 00 = 1025 words
    clear_log();
    start_load();
    send_word(32'h0000_0401);
    idle(3);
    #1;
    check("big_err",    32'(load_error), 1);
    check("big_hold",   32'(cpu_hold),   1);
    check("big_writes", 32'(we_cnt),     0);
    send_word(32'h0000_0001);            // ignored while in error
    #1 check("big_still_err", 32'(load_error), 1);
    start_load();
    #1;
    check("big_clear_err", 32'(load_error), 0);
    check("big_relen",     32'(busy),       1);

    // Zero length header straight after recovery
    send_word(32'h0000_0000);
    idle(2);
    #1;
    check("zero_done",   32'(done_cnt), 1);
    check("zero_writes", 32'(we_cnt),   0);
    check("zero_busy",   32'(busy),     0);
    check("zero_hold",   32'(cpu_hold), 0);

    // Gap of TIMEOUT_CYCLES-1 idle cycles is tolerated
    clear_log();
    start_load();
    send_word(32'h0000_0001);
    send(8'hAA);
    idle(TIMEOUT_CYCLES - 1);
    #1;
    check("tmo_edge_err",  32'(load_error), 0);
    check("tmo_edge_busy", 32'(busy),       1);
    send(8'hBB); send(8'hCC); send(8'hDD);
    idle(2);
    #1;
    check("tmo_edge_writes", 32'(we_cnt), 1);
    check("tmo_edge_data",   w_data[0],   32'hDDCC_BBAA);

    // Timeout after a partial word: no write
    clear_log();
    start_load();
    send_word(32'h0000_0001);
    send(8'h11); send(8'h22);
    idle(TIMEOUT_CYCLES);
    #1;
    check("tmo_err",    32'(load_error), 1);
    check("tmo_hold",   32'(cpu_hold),   1);
    check("tmo_writes", 32'(we_cnt),     0);

    // Restart mid-DATA after 3 bytes; the byte coinciding with the rise is dropped
    clear_log();
    start_load();
    send_word(32'h0000_0002);
    send(8'h11); send(8'h22); send(8'h33);
    flash = 1'b1;
    @(negedge clk);
    byte_valid = 1'b1; byte_data = 8'h44;
    @(negedge clk);
    byte_valid = 1'b0; flash = 1'b0;
    #1;
    check("rs_no_write", 32'(we_cnt), 0);
    check("rs_busy",     32'(busy),   1);
    send_word(32'h0000_0001);
    send_word(32'hEFBE_ADDE);            // bytes DE AD BE EF
    idle(2);
    #1;
    check("rs_writes", 32'(we_cnt),   1);
    check("rs_addr",   w_addr[0],     0);
    check("rs_data",   w_data[0],     32'hEFBE_ADDE);
    check("rs_done",   32'(done_cnt), 1);

    // Reset mid-DATA
    clear_log();
    start_load();
    send_word(32'h0000_0002);
    send(8'h01); send(8'h02); send(8'h03);
    rst = 1'b1; byte_valid = 1'b1; byte_data = 8'h04;
    @(negedge clk);
    #1;
    check("mr_we",    32'(imem_we),    0);
    check("mr_waddr", 32'(imem_waddr), 0);
    check("mr_wdata", imem_wdata,      0);
    check("mr_hold",  32'(cpu_hold),   0);
    check("mr_busy",  32'(busy),       0);
    check("mr_err",   32'(load_error), 0);
    rst = 1'b0; byte_valid = 1'b0;
    @(negedge clk);
    send_word(32'h0807_0605);
    idle(3);
    #1;
    check("mr_writes", 32'(we_cnt),   0);
    check("mr_idle",   32'(busy),     0);
    check("mr_done",   32'(done_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time controller that sequences instruction-memory programming over the UART byte stream. It sits between the UART receiver and the fetch stage's instruction memory write port. While loading, it holds the pipeline in reset. When a complete image has been written, it releases the core so execution starts from PC 0. It frames the byte stream (length header, then little-endian words), generates word writes, enforces a size limit and an inter-byte timeout, and reports done or error.

## Interface
- IMEM_DEPTH, 1024: instruction memory size in 32-bit words.
- TIMEOUT_CYCLES, 1_000_000: maximum clk cycles allowed between bytes while loading.
- ADDR_W, $clog2(IMEM_DEPTH): word-address width (derived).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- flash  in  1  load request level; a rising edge starts or restarts a load
- byte_valid  in  1  one-cycle strobe from UART receiver
- byte_data  in  8  received byte, valid with byte_valid
- imem_we  out  1  instruction memory write enable, one-cycle pulse
- imem_waddr  out  ADDR_W  word address of the write
- imem_wdata  out  32  write data
- cpu_hold  out  1  pipeline hold/reset request; high while loading or in error
- load_done  out  1  one-cycle pulse when an image completes
- load_error  out  1  sticky error flag
- busy  out  1  high in LEN or DATA

## Operation
- flash is registered once (flash_q). rise = flash & ~flash_q.
- States: IDLE, LEN, DATA, DONE, ERR.
- IDLE: cpu_hold=0. Bytes are ignored. On rise, go to LEN and clear byte_idx, word_idx, len and the timeout counter.
- LEN: collects 4 bytes into len, little-endian (first byte = len[7:0]). On the 4th byte:
  - len==0 goes to DONE.
  - len>IMEM_DEPTH goes to ERR.
  - Otherwise goes to DATA.
- DATA: each byte shifts into the word assembler, little-endian. On the 4th byte of a word:
  - Register imem_we=1, imem_waddr=word_idx, imem_wdata={b3,b2,b1,b0}.
  - Increment word_idx.
  - If word_idx==len-1, go to DONE.
- DONE: lasts exactly one cycle. load_done=1 and cpu_hold=0 in that cycle. Next state is IDLE.
- ERR: load_error=1 and cpu_hold=1. Stays in ERR until the next rise, which restarts at LEN and clears load_error, or until rst.
- Timeout: in LEN and DATA, a counter increments each cycle without byte_valid and clears on byte_valid. When it reaches TIMEOUT_CYCLES, go to ERR. A partial word is discarded and never written.
- A rise in LEN, DATA or ERR restarts at LEN with all counters cleared. Words already written are not erased.
- A rise and byte_valid in the same cycle: the rise wins and the byte is discarded.
- byte_valid in IDLE, DONE or ERR is ignored.
- byte_idx is 2 bits and wraps 3 to 0. word_idx is ADDR_W+1 bits and never exceeds IMEM_DEPTH because of the LEN check. len is 32 bits, compared unsigned.

## Timing
- Reset values: state=IDLE, imem_we=0, imem_waddr=0, imem_wdata=0, cpu_hold=0, load_done=0, load_error=0, busy=0. All counters are 0.
- rst asserted mid-load aborts immediately on the next edge. No further writes occur and all outputs return to reset values.
- Edge detect latency: flash rises at cycle t, the rise is visible at t+1, and cpu_hold=1 and busy=1 from t+2.
- Write latency: the 4th byte of a word strobes at cycle t, and imem_we is high during t+1 only.
- Completion: the last byte at t gives imem_we at t+1 and load_done at t+1, with cpu_hold low from t+1. The memory is written at the same edge that releases the core, so the first fetch sees the data.
- Outputs are all registered. There are no combinational paths from inputs to outputs.
- Back-to-back byte_valid on consecutive cycles is supported. Maximum throughput is one byte per cycle.

## Test plan
- Normal load: rise, then bytes 02 00 00 00, 13 00 00 00, B3 00 10 00. Expect imem writes (0, 0x00000013) and (1, 0x001000B3), load_done pulsed once, cpu_hold low afterwards.
- Oversize header: IMEM_DEPTH=1024, header 01 04 00 00 (1025). Expect ERR, load_error=1, cpu_hold=1, no imem_we. A later rise clears load_error and returns to LEN.
- Timeout: TIMEOUT_CYCLES=16, header for 1 word, send 2 bytes, then idle 16 cycles. Expect ERR and no write.
- Restart: rise mid-DATA after 3 bytes, with byte_valid in the same cycle. Expect the byte discarded, state LEN, byte_idx=0. A full new image then loads correctly.
- Zero length: header 00 00 00 00. Expect load_done with no writes, back to IDLE.
- Reset mid-load: assert rst during DATA. Expect all outputs 0 next cycle and bytes ignored until a new rise.
